// File: rtl/ctrl_edit_campos.sv
// Front-panel edit controller: button sync/debounce, field select FSM, counter enables.
// Optional AUTO_EXIT_EN macro adds an inactivity timeout that leaves EDIT.
module ctrl_edit_campos #(
    parameter int unsigned     DEB_CYCLES     = 1000000,
    parameter int unsigned     FIELD_MAX      = 6,
    parameter longint unsigned TIMEOUT_CYCLES = 64'd3000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_prog,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       edit_mode
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [3:0] FMAX = 4'(FIELD_MAX);

    localparam int B_PROG  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_LEFT  = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } state_t;

    generate
        if (FIELD_MAX < 2 || FIELD_MAX > 15) begin : g_chk_field
            $error("FIELD_MAX out of range");
        end
        if (DEB_CYCLES < 1) begin : g_chk_deb
            $error("DEB_CYCLES must be at least 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    logic [4:0] w_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_db;
    logic [2:0] r_db_q;
    logic [2:0] w_rise;

    state_t     r_state;
    state_t     w_state_nx;
    logic [3:0] r_field;
    logic [3:0] w_field_nx;
    logic       r_edit;
    logic       r_up;
    logic       r_down;
    logic       w_timeout;
    logic       w_edit_nx;

    assign w_raw = {btn_down, btn_up, btn_left, btn_right, btn_prog};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level only follows the synced input after DEB_CYCLES agreeing cycles.
    for (genvar g = 0; g < 5; g++) begin : g_deb
        logic [DW-1:0] r_cnt;
        logic          r_lvl;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[g] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_lvl <= r_sync2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db[g] = r_lvl;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_q <= '0;
        end else begin
            r_db_q <= w_db[2:0];
        end
    end

    assign w_rise = w_db[2:0] & ~r_db_q;

`ifdef AUTO_EXIT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_idle_cnt;

    assign w_timeout = (r_state == EDIT) && !(|w_db)
                       && (r_idle_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
        end else if (r_state != EDIT || (|w_db) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_field_nx = r_field;
        unique case (r_state)
            IDLE: begin
                if (w_rise[B_PROG]) begin
                    w_state_nx = EDIT;
                    w_field_nx = 4'd1;
                end
            end
            EDIT: begin
                if (w_rise[B_PROG] || w_timeout) begin
                    w_state_nx = IDLE;
                    w_field_nx = 4'd0;
                end else if (w_rise[B_RIGHT] && !w_rise[B_LEFT]) begin
                    w_field_nx = (r_field >= FMAX) ? 4'd1 : r_field + 4'd1;
                end else if (w_rise[B_LEFT] && !w_rise[B_RIGHT]) begin
                    w_field_nx = (r_field <= 4'd1) ? FMAX : r_field - 4'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_field_nx = 4'd0;
            end
        endcase
    end

    // Enables use the next state so they drop together with edit_mode.
    assign w_edit_nx = (w_state_nx == EDIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_field <= 4'd0;
            r_edit  <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_field <= w_field_nx;
            r_edit  <= w_edit_nx;
            r_up    <= w_edit_nx && w_db[B_UP] && !w_db[B_DOWN];
            r_down  <= w_edit_nx && w_db[B_DOWN] && !w_db[B_UP];
        end
    end

    assign en_count  = r_field;
    assign edit_mode = r_edit;
    assign enUP      = r_up;
    assign enDOWN    = r_down;

endmodule

// File: tb/tb_ctrl_edit_campos.sv
// Bench for ctrl_edit_campos: directed scenarios plus random buttons vs a behavioural model.
module tb_ctrl_edit_campos;

    localparam int     D  = 4;
    localparam int     FM = 6;
    localparam longint T  = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] btn = '0;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       edit_mode;

    int  nchk = 0;
    int  nerr = 0;
    bit  chk_en = 0;

    // Model state: synchronizer stages, debounced levels, disagreement run lengths.
    bit [4:0] m_s1, m_s2, m_db, m_dbq;
    int       m_run [5];
    bit       m_edit;
    int       m_field;
    bit       m_up, m_down;
    int       m_idle;

    always #5 clk = ~clk;

    ctrl_edit_campos #(
        .DEB_CYCLES    (D),
        .FIELD_MAX     (FM),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .btn_prog (btn[0]),
        .btn_right(btn[1]),
        .btn_left (btn[2]),
        .btn_up   (btn[3]),
        .btn_down (btn[4]),
        .en_count (en_count),
        .enUP     (enUP),
        .enDOWN   (enDOWN),
        .edit_mode(edit_mode)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_edit = 0; m_field = 0; m_up = 0; m_down = 0; m_idle = 0;
        end else begin
            bit [4:0] rise;
            bit [4:0] ndb;
            bit       nedit, to;
            int       nfield;
            rise   = m_db & ~m_dbq;
            nedit  = m_edit;
            nfield = m_field;
            to     = 0;
`ifdef AUTO_EXIT_EN
            to = m_edit && (m_db == 0) && (m_idle == T - 1);
`endif
            if (!m_edit) begin
                if (rise[0]) begin nedit = 1; nfield = 1; end
            end else if (rise[0] || to) begin
                nedit = 0; nfield = 0;
            end else if (rise[1] && !rise[2]) begin
                nfield = m_field % FM + 1;
            end else if (rise[2] && !rise[1]) begin
                nfield = (m_field + FM - 2) % FM + 1;
            end
            m_up   = nedit && m_db[3] && !m_db[4];
            m_down = nedit && m_db[4] && !m_db[3];
            m_idle = (!m_edit || m_db != 0 || to) ? 0 : m_idle + 1;
            ndb = m_db;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] == m_db[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == D) begin ndb[i] = m_s2[i]; m_run[i] = 0; end
                end
            end
            m_dbq   = m_db;
            m_db    = ndb;
            m_s2    = m_s1;
            m_s1    = btn;
            m_edit  = nedit;
            m_field = nfield;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            nchk++;
            if (en_count !== 4'(m_field) || enUP !== m_up ||
                enDOWN !== m_down || edit_mode !== m_edit) begin
                nerr++;
                $display("FAIL model t=%0t got en=%0d up=%b dn=%b ed=%b want en=%0d up=%b dn=%b ed=%b",
                         $time, en_count, enUP, enDOWN, edit_mode,
                         m_field, m_up, m_down, m_edit);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        cyc(D + 2);
        btn[idx] = 1'b0;
        cyc(D + 4);
    endtask

    initial begin
        bit bad;
        #1 rst_n = 1'b0;
        cyc(3);
        rst_n  = 1'b1;
        chk_en = 1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({en_count, enUP, enDOWN, edit_mode} !== 7'd0) bad = 1;
        end
        chk("reset_idle", 32'(bad), 0);

        btn[0] = 1'b1;
        cyc(6);
        chk("prog_lat_pre", 32'(en_count), 0);
        cyc(1);
        chk("prog_lat_field", 32'(en_count), 1);
        chk("prog_lat_edit", 32'(edit_mode), 1);
        cyc(3);
        btn[0] = 1'b0;
        cyc(D + 4);

        press(1);
        press(1);
        chk("right_twice", 32'(en_count), 3);

        btn[3] = 1'b1;
        cyc(8);
        chk("up_held", 32'({enUP, enDOWN}), 32'b10);
        btn[4] = 1'b1;
        cyc(8);
        chk("up_down_both", 32'({enUP, enDOWN}), 0);
        btn[4] = 1'b0;
        cyc(8);
        chk("up_again", 32'(enUP), 1);
        btn[0] = 1'b1;
        for (int i = 0; i < 20 && edit_mode; i++) @(negedge clk);
        chk("prog_exit_edit", 32'(edit_mode), 0);
        chk("prog_exit_same", 32'({en_count, enUP}), 0);
        btn = '0;
        cyc(D + 4);

        press(0);
        for (int i = 0; i < 5; i++) press(1);
        chk("field_six", 32'(en_count), 6);
        press(1);
        chk("wrap_right", 32'(en_count), 1);
        press(2);
        chk("wrap_left", 32'(en_count), 6);

        bad = 0;
        for (int len = 1; len <= 3; len++) begin
            btn[3] = 1'b1;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                if (enUP) bad = 1;
            end
            btn[3] = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (enUP) bad = 1;
            end
        end
        for (int i = 0; i < 20; i++) begin
            btn[3] = (i % 4) < 2;
            @(negedge clk);
            if (enUP || enDOWN) bad = 1;
        end
        btn[3] = 1'b0;
        cyc(8);
        chk("glitch_quiet", 32'(bad), 0);
        chk("glitch_field", 32'(en_count), 6);

        press(2);
        press(2);
        chk("field_four", 32'(en_count), 4);
        btn[4] = 1'b1;
        cyc(8);
        chk("down_held", 32'(enDOWN), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({en_count, enUP, enDOWN, edit_mode}), 0);
        @(negedge clk);
        btn = '0;
        rst_n = 1'b1;
        cyc(D + 4);

        press(0);
        cyc(100);
`ifdef AUTO_EXIT_EN
        chk("inactive", 32'(edit_mode), 0);
`else
        chk("inactive", 32'(edit_mode), 1);
`endif

        for (int s = 0; s < 2500; s++) begin
            btn[0] = ($urandom_range(9) == 0);
            btn[1] = ($urandom_range(2) == 0);
            btn[2] = ($urandom_range(2) == 0);
            btn[3] = ($urandom_range(2) == 0);
            btn[4] = ($urandom_range(2) == 0);
            cyc($urandom_range(12, 1));
        end
        btn = '0;
        cyc(20);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
